// File: rtl/spdif_encode.sv
// S/PDIF (IEC 60958) biphase-mark encoder for 16-bit stereo PCM.
// Each strobe emits one half-cell; samples are latched at the start of every frame.
module spdif_encode (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe,
  input  logic [15:0] sample_left,
  input  logic [15:0] sample_right,
  output logic        spdif,
  output logic        sample_req,
  output logic        block_start
);

  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  logic [5:0]  h_reg;
  logic        ch_reg;
  logic [7:0]  f_reg;
  logic [15:0] left_reg;
  logic [15:0] right_reg;
  logic        prev_level_reg;
  logic        spdif_reg;
  logic        sample_req_reg;
  logic        block_start_reg;

  logic        frame_start;
  logic [15:0] cur_sample;
  logic        c_bit;
  logic        parity_bit;
  logic [31:0] slot_bits;
  logic [4:0]  slot;
  logic [7:0]  preamble;
  logic        line_next;

  assign frame_start = strobe && (h_reg == 6'd0) && !ch_reg;
  assign cur_sample  = ch_reg ? right_reg : left_reg;
  assign slot        = h_reg[5:1];
  assign c_bit       = (f_reg == 8'd2) || (f_reg == 8'd25);
  // Aux, V and U are all zero, so parity only covers the sample and C.
  assign parity_bit  = (^cur_sample) ^ c_bit;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_slot
      if (gi >= 12 && gi <= 27) begin : g_data
        assign slot_bits[gi] = cur_sample[gi-12];
      end else if (gi == 30) begin : g_c
        assign slot_bits[gi] = c_bit;
      end else if (gi == 31) begin : g_p
        assign slot_bits[gi] = parity_bit;
      end else begin : g_zero
        assign slot_bits[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    preamble  = PRE_M;
    line_next = spdif_reg;
    if (ch_reg) begin
      preamble = PRE_W;
    end else if (f_reg == 8'd0) begin
      preamble = PRE_B;
    end
    if (h_reg < 6'd8) begin
      line_next = preamble[3'd7 - h_reg[2:0]] ^ prev_level_reg;
    end else if (!h_reg[0]) begin
      line_next = ~spdif_reg;
    end else begin
      line_next = spdif_reg ^ slot_bits[slot];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_reg           <= 6'd0;
      ch_reg          <= 1'b0;
      f_reg           <= 8'd0;
      left_reg        <= 16'd0;
      right_reg       <= 16'd0;
      prev_level_reg  <= 1'b0;
      spdif_reg       <= 1'b0;
      sample_req_reg  <= 1'b0;
      block_start_reg <= 1'b0;
    end else begin
      sample_req_reg  <= frame_start;
      block_start_reg <= frame_start && (f_reg == 8'd0);
      if (frame_start) begin
        left_reg  <= sample_left;
        right_reg <= sample_right;
      end
      if (strobe) begin
        spdif_reg <= line_next;
        h_reg     <= h_reg + 6'd1;
        // Line level at the end of a subframe seeds the next preamble.
        if (h_reg == 6'd63) begin
          prev_level_reg <= line_next;
          ch_reg         <= ~ch_reg;
          if (ch_reg) begin
            f_reg <= (f_reg == 8'd191) ? 8'd0 : f_reg + 8'd1;
          end
        end
      end
    end
  end

  assign spdif       = spdif_reg;
  assign sample_req  = sample_req_reg;
  assign block_start = block_start_reg;

endmodule

// File: tb/tb_spdif_encode.sv
// Randomized scoreboard bench for spdif_encode: a subframe-level reference model
// predicts each half-cell; a monitor compares one cycle after every strobe.
module tb_spdif_encode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        strobe = 1'b0;
  logic [15:0] sample_left = 16'd0;
  logic [15:0] sample_right = 16'd0;
  logic        spdif;
  logic        sample_req;
  logic        block_start;

  spdif_encode dut (
    .clk(clk),
    .reset(reset),
    .strobe(strobe),
    .sample_left(sample_left),
    .sample_right(sample_right),
    .spdif(spdif),
    .sample_req(sample_req),
    .block_start(block_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  int          m_h, m_ch, m_f;
  logic        m_prev;
  logic [15:0] m_left, m_right;
  logic        m_sub[64];
  int          exp_blk_count = 0;
  int          blk_seen = 0;
  logic [2:0]  exp_q[$];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {spdif,req,blk}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_ch = 0; m_f = 0; m_prev = 1'b0;
    m_left = 16'd0; m_right = 16'd0;
    exp_q.delete();
  endtask

  // Build the full 64 half-cell line waveform of the subframe about to start.
  task automatic build_subframe();
    logic        bits[32];
    logic [15:0] smp;
    logic [7:0]  pre;
    logic        p, level;
    smp = (m_ch == 1) ? m_right : m_left;
    for (int s = 0; s < 32; s++) bits[s] = 1'b0;
    for (int i = 0; i < 16; i++) bits[12+i] = smp[i];
    bits[30] = (m_f == 2 || m_f == 25);
    p = 1'b0;
    for (int s = 4; s <= 30; s++) p = p ^ bits[s];
    bits[31] = p;
    if (m_ch == 1)      pre = 8'b11100100;
    else if (m_f == 0)  pre = 8'b11101000;
    else                pre = 8'b11100010;
    for (int k = 0; k < 8; k++) m_sub[k] = pre[7-k] ^ m_prev;
    level = m_sub[7];
    for (int s = 4; s < 32; s++) begin
      level = ~level;
      m_sub[2*s] = level;
      if (bits[s]) level = ~level;
      m_sub[2*s+1] = level;
    end
  endtask

  task automatic model_step();
    logic req, blk;
    req = 1'b0; blk = 1'b0;
    if (m_h == 0) begin
      if (m_ch == 0) begin
        m_left = sample_left;
        m_right = sample_right;
        req = 1'b1;
        blk = (m_f == 0);
        if (blk) exp_blk_count++;
      end
      build_subframe();
    end
    exp_q.push_back({m_sub[m_h], req, blk});
    if (m_h == 63) begin
      m_prev = m_sub[63];
      m_h = 0;
      if (m_ch == 1) begin
        m_ch = 0;
        m_f = (m_f + 1) % 192;
      end else begin
        m_ch = 1;
      end
    end else begin
      m_h++;
    end
  endtask

  task automatic tick(input logic s);
    strobe = s;
    if (s) model_step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    strobe = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    reset = 1'b0;
    strobe = 1'b0;
    model_reset();
  endtask

  // Monitor: outputs register one cycle after the consuming edge.
  logic       strobe_d = 1'b0;
  logic       rst_d = 1'b1;
  logic       last_spdif = 1'b0;
  logic [2:0] mon_exp;

  always @(posedge clk) begin
    strobe_d <= strobe && !reset;
    rst_d    <= reset;
  end

  always @(negedge clk) begin
    if (rst_d) begin
      check("reset", {spdif, sample_req, block_start}, 3'b000);
      last_spdif = 1'b0;
    end else if (strobe_d) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL underflow: DUT strobe output with no expected entry at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("halfcell", {spdif, sample_req, block_start}, mon_exp);
        last_spdif = mon_exp[2];
      end
      if (block_start === 1'b1) blk_seen++;
    end else begin
      check("hold", {spdif, sample_req, block_start}, {last_spdif, 2'b00});
    end
  end

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();

    // B preamble after reset, then idle hold
    for (int i = 0; i < 8; i++) tick(1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0);

    // Known patterns: AAFF / 0000 and 0001 (odd parity payload)
    sample_left = 16'hAAFF; sample_right = 16'h0000;
    do_reset();
    for (int i = 0; i < 260; i++) tick(1'b1);
    sample_left = 16'h0001; sample_right = 16'h8000;
    do_reset();
    for (int i = 0; i < 260; i++) tick(1'b1);

    // Random strobe gaps, mid-frame sample changes, occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) sample_left = 16'($urandom);
      if ($urandom_range(0, 19) == 0) sample_right = 16'($urandom);
      if ($urandom_range(0, 999) == 0) do_reset();
      else tick($urandom_range(0, 2) != 0);
    end

    // Reset while at h=37 of the right subframe
    for (int i = 0; i < 200 && !(m_h == 37 && m_ch == 1); i++) tick(1'b1);
    n_cmp++;
    if (!(m_h == 37 && m_ch == 1)) begin
      n_fail++;
      $display("FAIL reach_h37: got h=%0d ch=%0d required h=37 ch=1", m_h, m_ch);
    end
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b1);

    // Full block and wrap into the next one
    do_reset();
    blk_seen = 0;
    exp_blk_count = 0;
    for (int i = 0; i < 192*128 + 300; i++) begin
      if ($urandom_range(0, 49) == 0) sample_left = 16'($urandom);
      if ($urandom_range(0, 49) == 0) sample_right = 16'($urandom);
      tick(1'b1);
    end
    for (int i = 0; i < 3; i++) tick(1'b0);

    n_cmp++;
    if (blk_seen != 2 || exp_blk_count != 2) begin
      n_fail++;
      $display("FAIL block_count: got %0d pulses (model %0d) required 2", blk_seen, exp_blk_count);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spdif_encode.md
SPDIF_ENCODE -- requirements
Module: spdif_encode

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock (38.4 MHz nominal); all logic on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port strobe, input, 1 bit: one-clk pulse per S/PDIF half-cell (128*fs, 6.144 MHz at 48 kHz); state advances only on strobe=1.
REQ-004 SHALL have port sample_left, input, 16 bits: left PCM sample, two's complement.
REQ-005 SHALL have port sample_right, input, 16 bits: right PCM sample, two's complement.
REQ-006 SHALL have port spdif, output, 1 bit: registered biphase-mark line output.
REQ-007 SHALL have port sample_req, output, 1 bit: one-clk pulse when both samples are latched.
REQ-008 SHALL have port block_start, output, 1 bit: one-clk pulse when a B preamble begins (frame 0 of a 192-frame block).

Function
REQ-009 Counters: half-cell index h (0..63) within subframe, channel ch (0=left, 1=right), frame f (0..191); all advance only on strobe.
REQ-010 On strobe: h increments; at h=63 wraps to 0 and ch toggles; when ch 1->0, f increments, 191 wraps to 0.
REQ-011 Slot s = h/2 (0..31); h even = first half-cell, h odd = second half-cell.
REQ-012 Slots 0-3 preamble, 8 half-cells, MSB first, referenced to previous line level 0: B (ch=0, f=0) 11101000; M (ch=0, f!=0) 11100010; W (ch=1) 11100100.
REQ-013 Preamble half-cells SHALL be XORed with the line level at end of previous subframe (constant by even parity; 0 after reset).
REQ-014 Slots 4-11 SHALL be 0 (aux + unused 24-bit LSBs).
REQ-015 Slots 12-27 SHALL carry the latched 16-bit sample, LSB in slot 12, MSB in slot 27.
REQ-016 Slot 28 (V) = 0; slot 29 (U) = 0.
REQ-017 Slot 30 (C) = channel-status bit f: 1 for f=2 (copy permitted) and f=25 (48 kHz code), 0 otherwise; identical on both channels.
REQ-018 Slot 31 (P) SHALL make slots 4-31 even-parity (P = XOR of slots 4-30).
REQ-019 Biphase mark for slots 4-31: line toggles at every even h; additionally toggles at odd h iff slot bit = 1.
REQ-020 spdif SHALL update in the clk cycle following the strobe that selects the half-cell (1-clk latency) and hold between strobes.
REQ-021 On strobe with h=0, ch=0: latch sample_left and sample_right into internal registers and pulse sample_req for that cycle; right subframe uses the value latched at its frame start.
REQ-022 block_start SHALL pulse in the same cycle as sample_req when f=0.
REQ-023 Inputs SHALL be sampled only at REQ-021 instant; changes at other times SHALL NOT affect the current frame.
REQ-024 strobe asserted in consecutive clk cycles SHALL advance one half-cell per cycle; no strobe = no state change.

Reset
REQ-025 With reset=1 at a clk edge: spdif=0, sample_req=0, block_start=0, h=0, ch=0, f=0, latched samples=0, previous-level=0; strobe ignored.
REQ-026 Reset mid-subframe SHALL abort the frame; first strobe after reset emits half-cell 0 of a B preamble (line 1) with sample_req and block_start pulsing.

Verification
REQ-027 Reset, then 8 strobes -> spdif sequence 1,1,1,0,1,0,0,0; sample_req and block_start pulse once on first strobe.
REQ-028 left=16'hAAFF, right=16'h0000; decode 64 half-cells of left -> slots 12-27 = FF then AA LSB-first, V=U=0, C=0, P=0; right slots 12-27 all 0, W preamble.
REQ-029 left=16'h0001 -> slot 12=1, P=1, line level at end of subframe = 0; next preamble not inverted.
REQ-030 Run 192*128 strobes -> B preamble only at frame 0 and again after wrap; M on frames 1-191; C=1 exactly on frames 2 and 25; block_start one pulse per block.
REQ-031 Change sample_left mid-frame -> current frame unchanged; new value appears next frame.
REQ-032 Assert reset at h=37 of right subframe -> spdif=0 next cycle; following strobes restart B preamble per REQ-027.
